// File: rtl/register_fetch_stage.sv
// Register-fetch stage: 32x64 register file, writeback bypass,
// busy-bit scoreboard with RAW/WAW stall, and one registered output slot.
// Ports:
//   clk/reset             clock, synchronous active-high reset
//   stackptr              value loaded into x2 at reset
//   in_*                  decoded instruction in, valid/ready handshake
//   wb_valid/wb_rd/wb_data  writeback port (also bypassed to reads)
//   flush                 kills the output slot, blocks acceptance
//   out_*                 registered slot to execute, valid/ready handshake
module register_fetch_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int REG_B  = 5,
  parameter int IMM_W  = 64,
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] stackptr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [REG_B-1:0]  in_rs1,
  input  logic [REG_B-1:0]  in_rs2,
  input  logic [REG_B-1:0]  in_rd,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic              in_writes_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_valid,
  input  logic [REG_B-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs1_val,
  output logic [DATA_W-1:0] out_rs2_val,
  output logic [REG_B-1:0]  out_rd,
  output logic              out_writes_rd,
  output logic [IMM_W-1:0]  out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam int NREG = 1 << REG_B;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [NREG-1:0]   busy_eff;

  logic              vld_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [REG_B-1:0]  rd_q;
  logic              wrd_q;
  logic [IMM_W-1:0]  imm_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              wb_hit;
  logic              haz;
  logic              accept;
  logic              wrd_in;

  assign wb_hit = wb_valid && (wb_rd != '0);
  assign wrd_in = in_writes_rd && (in_rd != '0);

  always_comb begin
    op1 = regs_q[in_rs1];
    if (in_rs1 == '0)
      op1 = '0;
    else if (wb_valid && wb_rd == in_rs1)
      op1 = wb_data;
  end

  always_comb begin
    op2 = regs_q[in_rs2];
    if (in_rs2 == '0)
      op2 = '0;
    else if (wb_valid && wb_rd == in_rs2)
      op2 = wb_data;
  end

  // A writeback landing this cycle releases its register's hazard;
  // the bypass above supplies the value.
  always_comb begin
    busy_eff = busy_q;
    if (wb_hit)
      busy_eff[wb_rd] = 1'b0;
    busy_eff[0] = 1'b0;
  end

  assign haz = (in_uses_rs1 && busy_eff[in_rs1])
            || (in_uses_rs2 && busy_eff[in_rs2])
            || (in_writes_rd && busy_eff[in_rd]);

  assign in_ready = !reset && !flush && !haz
                 && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Clears first, set last so a new writer wins on the same index.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit)
      busy_d[wb_rd] = 1'b0;
    if (flush && vld_q && wrd_q)
      busy_d[rd_q] = 1'b0;
    if (accept && wrd_in)
      busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      regs_q[2] <= DATA_W'(stackptr);
      busy_q    <= '0;
    end else begin
      if (wb_hit)
        regs_q[wb_rd] <= wb_data;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      rd_q   <= '0;
      wrd_q  <= 1'b0;
      imm_q  <= '0;
      ctrl_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      pc_q   <= in_pc;
      op1_q  <= op1;
      op2_q  <= op2;
      rd_q   <= in_rd;
      wrd_q  <= wrd_in;
      imm_q  <= in_imm;
      ctrl_q <= in_ctrl;
    end else if (vld_q && out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid     = vld_q;
  assign out_pc        = pc_q;
  assign out_rs1_val   = op1_q;
  assign out_rs2_val   = op2_q;
  assign out_rd        = rd_q;
  assign out_writes_rd = wrd_q;
  assign out_imm       = imm_q;
  assign out_ctrl      = ctrl_q;

endmodule

// File: tb/tb_register_fetch_stage.sv
// Directed bench for register_fetch_stage.
// Immediate assertions against hand-computed values.
module tb_register_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stackptr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [63:0] in_imm;
  logic [31:0] in_ctrl;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_writes_rd;
  logic [63:0] out_imm;
  logic [31:0] out_ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_fetch_stage dut (
    .clk(clk), .reset(reset), .stackptr(stackptr),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_writes_rd(in_writes_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_imm(out_imm),
    .out_ctrl(out_ctrl)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = '0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0;
    in_imm = '0; in_ctrl = '0;
    wb_valid = 0; wb_rd = 0; wb_data = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [63:0] pc,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr);
    in_valid = 1; in_pc = pc;
    in_rs1 = rs1; in_uses_rs1 = u1;
    in_rs2 = rs2; in_uses_rs2 = u2;
    in_rd = rd; in_writes_rd = wr;
    in_imm = pc + 64'h1000; in_ctrl = pc[31:0] ^ 32'hA5A5_0000;
  endtask

  initial begin
    idle();
    reset = 1;
    stackptr = 64'h7FFF_F000;
    settle();
    chk("rst_in_ready", in_ready, 0);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rs1", out_rs1_val, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    reset = 0;

    // 1: x2 holds stackptr, x0 reads zero
    issue(64'h100, 2, 1, 0, 1, 3, 0);
    settle();
    chk("t1_in_ready", in_ready, 1);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_rs1", out_rs1_val, 64'h7FFF_F000);
    chk("t1_rs2", out_rs2_val, 0);
    chk("t1_pc", out_pc, 64'h100);
    chk("t1_imm", out_imm, 64'h1100);
    chk("t1_ctrl", out_ctrl, 32'hA5A5_0100);
    chk("t1_wrd", out_writes_rd, 0);
    in_valid = 0;
    step();
    chk("t1_drain", out_valid, 0);

    // 2: same-cycle writeback bypass
    wb_valid = 1; wb_rd = 5; wb_data = 64'hDEAD;
    issue(64'h104, 5, 1, 0, 0, 0, 0);
    settle();
    chk("t2_in_ready", in_ready, 1);
    step();
    chk("t2_rs1_byp", out_rs1_val, 64'hDEAD);
    wb_valid = 0;
    issue(64'h108, 5, 1, 0, 0, 0, 0);
    step();
    chk("t2_rs1_reg", out_rs1_val, 64'hDEAD);
    chk("t2_pc", out_pc, 64'h108);

    // 3: RAW stall until writeback of x7
    issue(64'h10C, 0, 0, 0, 0, 7, 1);
    step();
    chk("t3_rd", out_rd, 7);
    chk("t3_wrd", out_writes_rd, 1);
    issue(64'h110, 0, 0, 7, 1, 0, 0);
    settle();
    chk("t3_stall0", in_ready, 0);
    step();
    chk("t3_bubble", out_valid, 0);
    chk("t3_stall1", in_ready, 0);
    step();
    chk("t3_stall2", in_ready, 0);
    wb_valid = 1; wb_rd = 7; wb_data = 64'h55;
    settle();
    chk("t3_release", in_ready, 1);
    step();
    chk("t3_rs2", out_rs2_val, 64'h55);
    chk("t3_pc", out_pc, 64'h110);
    wb_valid = 0;

    // 4: backpressure holds the slot, then no-bubble replace
    out_ready = 0;
    issue(64'h200, 5, 1, 0, 0, 0, 0);
    settle();
    chk("t4_bp_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_pc", out_pc, 64'h110);
      chk("t4_hold_rs2", out_rs2_val, 64'h55);
      chk("t4_hold_ready", in_ready, 0);
    end
    out_ready = 1;
    settle();
    chk("t4_go_ready", in_ready, 1);
    step();
    chk("t4_new_valid", out_valid, 1);
    chk("t4_new_pc", out_pc, 64'h200);
    chk("t4_new_rs1", out_rs1_val, 64'hDEAD);

    // 5: x0 ignores writes and never goes busy
    wb_valid = 1; wb_rd = 0; wb_data = 64'hFFFF;
    issue(64'h300, 0, 1, 0, 0, 0, 0);
    step();
    chk("t5_x0_byp", out_rs1_val, 0);
    wb_valid = 0;
    issue(64'h304, 0, 1, 0, 0, 0, 1);
    step();
    chk("t5_x0_wrd", out_writes_rd, 0);
    chk("t5_x0_rd", out_rd, 0);
    issue(64'h308, 0, 1, 0, 0, 0, 1);
    settle();
    chk("t5_x0_nostall", in_ready, 1);
    step();
    chk("t5_x0_read", out_rs1_val, 0);
    chk("t5_pc", out_pc, 64'h308);

    // 6: flush kills slot and releases busy[9]
    issue(64'h400, 0, 0, 0, 0, 9, 1);
    step();
    chk("t6_rd", out_rd, 9);
    in_valid = 0; out_ready = 0;
    flush = 1;
    settle();
    chk("t6_flush_ready", in_ready, 0);
    step();
    chk("t6_flushed", out_valid, 0);
    flush = 0; out_ready = 1;
    issue(64'h404, 9, 1, 0, 0, 0, 0);
    settle();
    chk("t6_no_stall", in_ready, 1);
    step();
    chk("t6_valid", out_valid, 1);
    chk("t6_pc", out_pc, 64'h404);

    // reset mid-operation with a busy x12 and a live slot
    issue(64'h408, 0, 0, 0, 0, 12, 1);
    step();
    chk("t6_pre_valid", out_valid, 1);
    stackptr = 64'h8000;
    reset = 1;
    issue(64'h500, 0, 0, 0, 0, 0, 0);
    settle();
    chk("t6_rst_ready", in_ready, 0);
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pc", out_pc, 0);
    reset = 0;
    issue(64'h600, 2, 1, 0, 0, 12, 1);
    settle();
    chk("t6_busy_clr", in_ready, 1);
    step();
    chk("t6_sp_reload", out_rs1_val, 64'h8000);
    chk("t6_post_pc", out_pc, 64'h600);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
